// File: rtl/neuron_c_bwd_pkg.sv
// neuron_c_bwd shared definitions
// Q8.24 format constants and FSM encoding
package neuron_c_bwd_pkg;
  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam logic [WIDTH-1:0] Q_ONE = 32'h0100_0000;
  localparam logic [WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_Q.sv
// Fixed-point multiplier, two lanes
// Each lane returns (x*y)>>>FBITS truncated
module mult_Q
  import neuron_c_bwd_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int F = FBITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic signed [2*W-1:0] full_p;
  logic signed [2*W-1:0] full_q;

  // signed products, scaled back to Q format
  always_comb begin
    full_p = $signed(a) * $signed(b);
    full_q = $signed(c) * $signed(d);
    p = W'(full_p >>> F);
    q = W'(full_q >>> F);
  end
endmodule

// File: rtl/neuron_c_bwd_sat_sub.sv
// Saturating subtract y = sat(a - b)
// Computed at W+1 bits, clamped to Q_MAX/Q_MIN
module sat_sub_Q #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W:0] diff;

  // overflow when the two top bits disagree
  always_comb begin
    diff = {a[W-1], a} - {b[W-1], b};
    if (diff[W] != diff[W-1])
      y = diff[W] ? {1'b1, {(W-1){1'b0}}}
                  : {1'b0, {(W-1){1'b1}}};
    else
      y = diff[W-1:0];
  end
endmodule

// File: rtl/neuron_c_bwd.sv
// Sigmoid neuron backward pass
// One shared multiplier sequenced over 8 steps
module neuron_c_bwd
  import neuron_c_bwd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] a_2,
  input  logic [WIDTH-1:0] a_3,
  input  logic [WIDTH-1:0] w_1,
  input  logic [WIDTH-1:0] w_2,
  input  logic [WIDTH-1:0] w_3,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] err,
  input  logic [WIDTH-1:0] lr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w_1_new,
  output logic [WIDTH-1:0] w_2_new,
  output logic [WIDTH-1:0] w_3_new,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] e_1,
  output logic [WIDTH-1:0] e_2,
  output logic [WIDTH-1:0] e_3,
  output logic [WIDTH-1:0] delta
);
  state_t state, nxt;
  logic [2:0] cnt;

  logic [WIDTH-1:0] a1_r, a2_r, a3_r;
  logic [WIDTH-1:0] w1_r, w2_r, w3_r;
  logic [WIDTH-1:0] b_r, y_r, err_r, lr_r;
  logic [WIDTH-1:0] yd, ld;

  logic [WIDTH-1:0] mx, my, prod, prod2;
  logic [WIDTH-1:0] sa, diff;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else if (en) state <= nxt;
  end

  // next state and handshake
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid) nxt = CALC;
      CALC: if (cnt == 3'd7) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // operand select for multiplier and subtractor
  always_comb begin
    mx = '0;
    my = '0;
    sa = '0;
    unique case (cnt)
      3'd0: begin mx = y_r; my = Q_ONE - y_r; end
      3'd1: begin mx = err_r; my = yd; end
      3'd2: begin mx = lr_r; my = delta; sa = b_r; end
      3'd3: begin mx = ld; my = a1_r; sa = w1_r; end
      3'd4: begin mx = ld; my = a2_r; sa = w2_r; end
      3'd5: begin mx = ld; my = a3_r; sa = w3_r; end
      3'd6: begin mx = delta; my = w1_r; end
      3'd7: begin mx = delta; my = w2_r; end
      default: ;
    endcase
  end

  mult_Q u_mul (
    .a(mx),
    .b(my),
    .p(prod),
    .c(delta),
    .d(w3_r),
    .q(prod2)
  );

  sat_sub_Q #(.W(WIDTH)) u_sub (
    .a(sa),
    .b(prod),
    .y(diff)
  );

  // capture, step sequencing and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      a1_r <= '0; a2_r <= '0; a3_r <= '0;
      w1_r <= '0; w2_r <= '0; w3_r <= '0;
      b_r <= '0; y_r <= '0;
      err_r <= '0; lr_r <= '0;
      yd <= '0; ld <= '0;
      delta <= '0; b_new <= '0;
      w_1_new <= '0; w_2_new <= '0;
      w_3_new <= '0;
      e_1 <= '0; e_2 <= '0; e_3 <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= (nxt == DONE);
      if (state == IDLE && in_valid) begin
        cnt <= '0;
        a1_r <= a_1; a2_r <= a_2; a3_r <= a_3;
        w1_r <= w_1; w2_r <= w_2; w3_r <= w_3;
        b_r <= b; y_r <= y;
        err_r <= err; lr_r <= lr;
      end
      if (state == CALC) begin
        cnt <= cnt + 3'd1;
        unique case (cnt)
          3'd0: yd <= prod;
          3'd1: delta <= prod;
          3'd2: begin ld <= prod; b_new <= diff; end
          3'd3: w_1_new <= diff;
          3'd4: w_2_new <= diff;
          3'd5: w_3_new <= diff;
          3'd6: e_1 <= prod;
          3'd7: begin e_2 <= prod; e_3 <= prod2; end
          default: ;
        endcase
      end
    end
  end
endmodule
